// File: rtl/hazard_sched.sv
// Hazard/stall scheduler for the 5-stage pipeline: stall, flush, forwarding and MCycle/cache FSMs.
// Build macro HAZARD_FWD_EN: defined -> operand forwarding + load-use stall only; undefined -> RAW stall, no forwarding.
module hazard_sched #(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 7
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] RA1D,
   input  logic [3:0] RA2D,
   input  logic [3:0] RA1E,
   input  logic [3:0] RA2E,
   input  logic [3:0] WA3E,
   input  logic [3:0] WA3M,
   input  logic [3:0] WA3W,
   input  logic       RegWE,
   input  logic       RegWM,
   input  logic       RegWW,
   input  logic       MemtoRegE,
   input  logic       BranchTakenE,
   input  logic       StartE,
   input  logic       MDone,
   input  logic       CacheMiss,
   input  logic       CacheReady,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
   output logic       Mstall,
   output logic       Cache_Stall,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       McTimeout
);

   typedef enum logic [1:0] {MC_IDLE, MC_BUSY, MC_HOLD} mc_state_t;
   typedef enum logic       {CA_IDLE, CA_WAIT}          ca_state_t;

   mc_state_t        r_mc_state;
   ca_state_t        r_ca_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   logic       w_raw_stall;
   logic       w_mstall;
   logic       w_cache_stall;
   logic       w_frz;
   logic       w_mc_last;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   // R15 is the PC, never a real data dependency.
   function automatic logic reg_match(input logic [3:0] a, input logic [3:0] b);
      return (a == b) && (a != 4'd15);
   endfunction

`ifdef HAZARD_FWD_EN
   function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
      if (RegWM && reg_match(WA3M, ra))
         return 2'b10;
      else if (RegWW && reg_match(WA3W, ra))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign w_raw_stall = MemtoRegE & RegWE & (reg_match(WA3E, RA1D) | reg_match(WA3E, RA2D));
   assign w_fwd_a     = fwd_sel(RA1E);
   assign w_fwd_b     = fwd_sel(RA2E);
`else
   logic w_unused_fwd;

   assign w_raw_stall  = (RegWE & (reg_match(WA3E, RA1D) | reg_match(WA3E, RA2D)))
                       | (RegWM & (reg_match(WA3M, RA1D) | reg_match(WA3M, RA2D)));
   assign w_fwd_a      = 2'b00;
   assign w_fwd_b      = 2'b00;
   assign w_unused_fwd = ^{RA1E, RA2E, WA3W, RegWW, MemtoRegE};
`endif

   assign w_mc_last = (r_cnt == CNT_W'(MC_TIMEOUT - 1));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_cache_stall = 1'b0;
      case (r_ca_state)
         CA_IDLE: w_cache_stall = CacheMiss;
         CA_WAIT: w_cache_stall = ~CacheReady;
         default: w_cache_stall = 1'b0;
      endcase
   end

   always_comb begin
      w_mstall = 1'b0;
      case (r_mc_state)
         MC_IDLE: w_mstall = StartE;
         MC_BUSY: w_mstall = ~MDone & ~w_mc_last;
         default: w_mstall = 1'b0;
      endcase
   end

   assign w_frz = w_mstall | w_cache_stall;

   // Flush only when E can move; the D/E register would otherwise lose a frozen op.
   assign StallF      = ~RESET & (w_raw_stall | w_frz);
   assign StallD      = ~RESET & (w_raw_stall | w_frz);
   assign FlushD      = ~RESET & BranchTakenE & ~w_frz;
   assign FlushE      = ~RESET & (w_raw_stall | BranchTakenE) & ~w_frz;
   assign Mstall      = ~RESET & w_mstall;
   assign Cache_Stall = ~RESET & w_cache_stall;
   assign ForwardAE   = RESET ? 2'b00 : w_fwd_a;
   assign ForwardBE   = RESET ? 2'b00 : w_fwd_b;
   assign McTimeout   = r_timeout;

   // NOTE: state registers use non-blocking assignments so all FSMs sample the same pre-edge values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_mc_state <= MC_IDLE;
         r_ca_state <= CA_IDLE;
         r_cnt      <= '0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_mc_state)
            MC_IDLE: begin
               if (StartE) begin
                  r_mc_state <= MC_BUSY;
                  r_cnt      <= '0;
               end
            end
            MC_BUSY: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (MDone)
                  r_mc_state <= w_cache_stall ? MC_HOLD : MC_IDLE;
               else if (w_mc_last) begin
                  r_mc_state <= MC_IDLE;
                  r_timeout  <= 1'b1;
               end
            end
            // Result already delivered; wait out the cache freeze without re-issuing.
            MC_HOLD: begin
               if (!w_cache_stall)
                  r_mc_state <= MC_IDLE;
            end
            default: r_mc_state <= MC_IDLE;
         endcase

         if (r_ca_state == CA_IDLE) begin
            if (CacheMiss)
               r_ca_state <= CA_WAIT;
         end else if (CacheReady) begin
            r_ca_state <= CA_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched with a transaction-level reference model checked every cycle.
module tb_hazard_sched;
   localparam int TO = 8;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
   logic       RegWE, RegWM, RegWW, MemtoRegE, BranchTakenE;
   logic       StartE, MDone, CacheMiss, CacheReady;
   logic       StallF, StallD, FlushD, FlushE, Mstall, Cache_Stall, McTimeout;
   logic [1:0] ForwardAE, ForwardBE;

   int n_pass  = 0;
   int n_total = 0;

   always #5 CLK = ~CLK;

   hazard_sched #(.MC_TIMEOUT(TO), .CNT_W(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWE(RegWE), .RegWM(RegWM), .RegWW(RegWW),
      .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
      .StartE(StartE), .MDone(MDone), .CacheMiss(CacheMiss), .CacheReady(CacheReady),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .Mstall(Mstall), .Cache_Stall(Cache_Stall),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McTimeout(McTimeout)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       stallf, stalld, flushd, flushe, mstall, cstall;
      logic [1:0] fa, fb;
   } exp_t;

   bit mc_running, mc_parked, cache_waiting, timed_out;
   int mc_age;   // completed BUSY cycles since issue

   function automatic bit hit(input logic [3:0] a, input logic [3:0] b);
      return (a == b) && (a != 4'd15);
   endfunction

   function automatic logic [1:0] fwd(input logic [3:0] ra);
`ifdef HAZARD_FWD_EN
      if (RegWM && hit(WA3M, ra)) return 2'b10;
      if (RegWW && hit(WA3W, ra)) return 2'b01;
`endif
      return 2'b00;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      bit raw, frz;
      e = '0;
      if (RESET) return e;
`ifdef HAZARD_FWD_EN
      raw = MemtoRegE && RegWE && (hit(WA3E, RA1D) || hit(WA3E, RA2D));
`else
      raw = (RegWE && (hit(WA3E, RA1D) || hit(WA3E, RA2D)))
         || (RegWM && (hit(WA3M, RA1D) || hit(WA3M, RA2D)));
`endif
      if (mc_running)     e.mstall = !MDone && (mc_age != TO - 1);
      else if (mc_parked) e.mstall = 1'b0;
      else                e.mstall = StartE;
      e.cstall = cache_waiting ? !CacheReady : CacheMiss;
      frz      = e.mstall || e.cstall;
      e.stallf = raw || frz;
      e.stalld = raw || frz;
      e.flushd = BranchTakenE && !frz;
      e.flushe = (raw || BranchTakenE) && !frz;
      e.fa     = fwd(RA1E);
      e.fb     = fwd(RA2E);
      return e;
   endfunction

   always @(posedge CLK or posedge RESET) begin
      exp_t e;
      if (RESET) begin
         mc_running = 0; mc_parked = 0; cache_waiting = 0; timed_out = 0; mc_age = 0;
      end else begin
         e = model_out();
         if (mc_running) begin
            if (MDone) begin
               mc_running = 0;
               mc_parked  = e.cstall;
            end else if (mc_age == TO - 1) begin
               mc_running = 0;
               timed_out  = 1;
            end
            mc_age++;
         end else if (mc_parked) begin
            if (!e.cstall) mc_parked = 0;
         end else if (StartE) begin
            mc_running = 1;
            mc_age     = 0;
         end
         if (cache_waiting) cache_waiting = !CacheReady;
         else               cache_waiting = CacheMiss;
      end
   end

   always @(negedge CLK) begin
      exp_t e;
      e = model_out();
      check("cycle_outputs",
            16'({StallF, StallD, FlushD, FlushE, Mstall, Cache_Stall, ForwardAE, ForwardBE}),
            16'(e));
      check("cycle_mctimeout", 16'(McTimeout), 16'(timed_out));
   end

   // ---------------- directed stimulus ----------------
   task automatic clear_inputs();
      RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
      RegWE = 0; RegWM = 0; RegWW = 0; MemtoRegE = 0; BranchTakenE = 0;
      StartE = 0; MDone = 0; CacheMiss = 0; CacheReady = 0;
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic settle();
      @(negedge CLK); #1;
   endtask

   initial begin
      RESET = 1'b1;
      clear_inputs();
      StartE = 1; BranchTakenE = 1; CacheMiss = 1; MemtoRegE = 1; RegWE = 1; WA3E = 2; RA1D = 2;
      settle();
      check("rst_stall", 16'({StallF, StallD}), 16'b00);
      check("rst_flush", 16'({FlushD, FlushE}), 16'b00);
      check("rst_mc_cache", 16'({Mstall, Cache_Stall, McTimeout}), 16'b000);
      tick(); tick();
      clear_inputs();
      RESET = 1'b0;
      tick();

      // Load-use stall, then bubble
      MemtoRegE = 1; RegWE = 1; WA3E = 3; RA2D = 3;
      settle();
      check("ldr_stall", 16'({StallF, StallD, FlushE, FlushD}), 16'b1110);
      tick(); clear_inputs();
      settle();
      check("ldr_after", 16'({StallF, StallD, FlushE, FlushD}), 16'b0000);
      tick();

      // R15 never matches
      MemtoRegE = 1; RegWE = 1; WA3E = 15; RA1D = 15; RA2D = 15; RegWM = 1; WA3M = 15;
      settle();
      check("r15_no_stall", 16'(StallF), 16'b0);
      tick(); clear_inputs();

      // Non-load dependency on M
      RegWM = 1; WA3M = 4; RA1D = 4;
      settle();
`ifdef HAZARD_FWD_EN
      check("m_dep_stall", 16'(StallF), 16'b0);
`else
      check("m_dep_stall", 16'(StallF), 16'b1);
`endif
      tick(); clear_inputs();

      // Branch flush, then branch suppressed by a cache miss
      BranchTakenE = 1;
      settle();
      check("br_flush", 16'({FlushD, FlushE}), 16'b11);
      tick();
      CacheMiss = 1;
      settle();
      check("br_frozen", 16'({FlushD, FlushE, Cache_Stall, StallF}), 16'b0011);
      tick(); clear_inputs();
      settle();
      check("cache_wait", 16'(Cache_Stall), 16'b1);
      tick();
      CacheReady = 1;
      settle();
      check("cache_ready", 16'(Cache_Stall), 16'b0);
      tick(); clear_inputs();

      // MCycle with MDone 5 cycles after issue
      StartE = 1;
      for (int k = 0; k <= 5; k++) begin
         MDone = (k == 5);
         settle();
         check($sformatf("mc_k%0d", k), 16'(Mstall), 16'(k < 5));
         tick();
      end
      clear_inputs();
      settle();
      check("mc_done_idle", 16'({Mstall, McTimeout}), 16'b00);
      tick();

      // Overlap: StartE + CacheMiss, MDone at +3, CacheReady at +6
      for (int k = 0; k <= 6; k++) begin
         StartE = 1; CacheMiss = (k == 0); MDone = (k == 3); CacheReady = (k == 6);
         settle();
         check($sformatf("ovl_k%0d", k), 16'({Mstall, Cache_Stall, StallF}),
               16'({k < 3, k < 6, k < 6}));
         tick();
      end
      clear_inputs();
      settle();
      check("ovl_idle", 16'({Mstall, Cache_Stall}), 16'b00);
      tick();

      // Forwarding
      RA1E = 5; RA2E = 5; RegWM = 1; WA3M = 5; RegWW = 1; WA3W = 5;
      settle();
`ifdef HAZARD_FWD_EN
      check("fwd_m_prio", 16'({ForwardAE, ForwardBE}), 16'b1010);
`else
      check("fwd_m_prio", 16'({ForwardAE, ForwardBE}), 16'b0000);
`endif
      tick();
      RegWM = 0;
      settle();
`ifdef HAZARD_FWD_EN
      check("fwd_w", 16'({ForwardAE, ForwardBE}), 16'b0101);
`else
      check("fwd_w", 16'({ForwardAE, ForwardBE}), 16'b0000);
`endif
      tick();
      RA1E = 15; WA3W = 15;
      settle();
      check("fwd_r15", 16'(ForwardAE), 16'b00);
      tick(); clear_inputs();

      // Watchdog: no MDone
      StartE = 1;
      for (int k = 0; k <= TO; k++) begin
         settle();
         check($sformatf("wd_k%0d", k), 16'({Mstall, McTimeout}), 16'({k < TO, 1'b0}));
         tick();
      end
      clear_inputs();
      for (int k = 0; k < 3; k++) begin
         settle();
         check($sformatf("wd_sticky%0d", k), 16'({McTimeout, Mstall}), 16'b10);
         tick();
      end
      RESET = 1;
      settle();
      check("wd_cleared", 16'(McTimeout), 16'b0);
      tick();
      RESET = 0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Central hazard and stall scheduler for the 5-stage pipeline (F/D/E/M/W).
- Generates the stall, flush and forwarding controls consumed by the F/D, D/E and E/M stage registers.
- Sequences multicycle (MCycle) operations and cache-miss waits through two small FSMs.
- Guarantees FlushE is never asserted while E is frozen, because the D/E register gives flush priority over stall.

Parameters:
MC_TIMEOUT, 64, max cycles BUSY waits for MDone before forced release
CNT_W, 7, width of MCycle watchdog counter (must hold MC_TIMEOUT)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
RA1D, RA2D  in  4  D-stage source registers
RA1E, RA2E  in  4  E-stage source registers
WA3E, WA3M, WA3W  in  4  destination register in E/M/W
RegWE, RegWM, RegWW  in  1  register write enables in E/M/W
MemtoRegE  in  1  E-stage instruction is a load
BranchTakenE  in  1  PC redirect resolved in E
StartE  in  1  multicycle op present in E
MDone  in  1  MCycle unit result valid (1-cycle pulse)
CacheMiss  in  1  D-cache miss detected this cycle
CacheReady  in  1  refill complete (1-cycle pulse)
StallF, StallD  out  1  hold PC and F/D register
FlushD, FlushE  out  1  clear F/D and D/E registers
Mstall  out  1  multicycle stall (to all stage registers)
Cache_Stall  out  1  cache stall (to all stage registers)
ForwardAE, ForwardBE  out  2  E operand select: 00 reg file, 01 W result, 10 M result
McTimeout  out  1  sticky watchdog-expired flag

Behaviour:
- RESET asserted: both FSMs to IDLE, counter=0, McTimeout=0, and all outputs forced to 0 while RESET is high. Deassertion takes effect at the next CLK edge.
- Register R15 never matches for forwarding or hazard detection.
- LDRstall (combinational) = MemtoRegE & RegWE & (WA3E==RA1D | WA3E==RA2D).
- MCycle FSM states: IDLE, BUSY, HOLD.
  - IDLE: StartE -> BUSY, counter cleared. Mstall=StartE, combinational, so E holds in the issue cycle.
  - BUSY: Mstall = ~MDone, and the counter increments each cycle.
    - MDone & ~Cache_Stall -> IDLE.
    - MDone & Cache_Stall -> HOLD.
    - counter==MC_TIMEOUT-1 without MDone -> IDLE, McTimeout<=1, and Mstall=0 that cycle.
  - HOLD: Mstall=0 and StartE is ignored, which prevents re-issue of the frozen op. ~Cache_Stall -> IDLE.
- Cache FSM states: IDLE, WAIT.
  - IDLE: Cache_Stall = CacheMiss. CacheMiss -> WAIT.
  - WAIT: Cache_Stall = ~CacheReady. CacheReady -> IDLE, and the stall drops in the CacheReady cycle.
- Simultaneous StartE and CacheMiss: both FSMs advance independently. The pipeline is frozen while either stall is high, and the watchdog keeps counting during cache waits.
- Stall/flush equations, with Frz = Mstall | Cache_Stall:
  - StallF = StallD = LDRstall | Frz.
  - FlushD = BranchTakenE & ~Frz.
  - FlushE = (LDRstall | BranchTakenE) & ~Frz.
- Forwarding for operand A (B is identical using RA2E):
  - 10 if RegWM & WA3M==RA1E.
  - else 01 if RegWW & WA3W==RA1E.
  - else 00.
  - M has priority over W.
- Latency: all stall/flush/forward outputs are combinational from inputs and FSM state, with no added cycle. FSM state updates on the CLK edge.

Optional Feature:
HAZARD_FWD_EN
- Defined: forwarding as above, and only loads cause a RAW stall (LDRstall).
- Undefined: ForwardAE=ForwardBE=00 constant. LDRstall is replaced by RAWstall = (RegWE & WA3E matches RA1D/RA2D) | (RegWM & WA3M matches RA1D/RA2D). The register file's write-first behaviour covers the W stage. Stall and flush equations use RAWstall in place of LDRstall.

Test Plan:
- Load-use: MemtoRegE=1, RegWE=1, WA3E=3, RA2D=3 -> StallF=StallD=FlushE=1 for 1 cycle, FlushD=0; next cycle all 0.
- Branch: BranchTakenE=1, no stall -> FlushD=FlushE=1. The same input with CacheMiss=1 -> FlushD=FlushE=0, Cache_Stall=1.
- MCycle: StartE=1 held, MDone pulsed 5 cycles later -> Mstall=1 for 5 cycles, 0 in the MDone cycle, FSM IDLE; McTimeout stays 0.
- Watchdog: MC_TIMEOUT=8, StartE=1, no MDone -> Mstall drops after 8 cycles, McTimeout=1 sticky until RESET.
- Overlap: StartE and CacheMiss in the same cycle, MDone at +3, CacheReady at +6 -> FSM enters HOLD at +3 and Mstall=0 from +3. Cache_Stall=1 through +5 and drops at +6. FSM returns to IDLE, no re-issue, StallF=0 at +6.
- Forwarding (HAZARD_FWD_EN defined): RA1E=5, RegWM=1 with WA3M=5, RegWW=1 with WA3W=5 -> ForwardAE=10. With RegWM=0 -> ForwardAE=01. With RA1E=15 -> ForwardAE=00.
